// File: rtl/apb_fifo_ctrl.sv
// apb_fifo_ctrl
//   APB slave wrapping a synchronous FIFO with run-time depth selection,
//   programmable almost-full/almost-empty thresholds, sticky overflow and
//   underflow errors, flush and a maskable level interrupt.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PADDR[31]            1 = FIFO data port, 0 = register space
//   PADDR[4:2]           register index (valid offsets 0x00..0x1C)
//   PPROT                unused
//   PSEL/PENABLE/PWRITE  APB control; access phase = PSEL & PENABLE
//   PWDATA, PSTRB        write data, byte strobes for register writes
//   PREADY               always 1
//   PRDATA, PSLVERR      combinational read data / error in access phase
//   full, empty, almost_full, almost_empty   status from registered count
//   irq                  |(INT_STAT & INT_EN)
module apb_fifo_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_DEPTH = 256,
  parameter int unsigned AF_RESET  = 6,
  parameter int unsigned AE_RESET  = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic [2:0]  PPROT,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic        almost_empty,
  output logic        irq
);

  localparam int unsigned AW = $clog2(MAX_DEPTH);
  localparam int unsigned CW = AW + 1;

  // State
  logic [WIDTH-1:0] mem [MAX_DEPTH];
  logic [AW-1:0]    w_ptr_q, w_ptr_d;
  logic [AW-1:0]    r_ptr_q, r_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       depth_sel_q, depth_sel_d;
  logic [15:0]      af_thresh_q, af_thresh_d;
  logic [15:0]      ae_thresh_q, ae_thresh_d;
  logic [3:0]       int_en_q, int_en_d;
  logic [3:0]       int_stat_q, int_stat_d;
  logic             af_prev_q, af_prev_d;
  logic             ae_prev_q, ae_prev_d;

  // Decode
  logic       access, addr_ok, data_sel, reg_sel;
  logic [2:0] reg_idx;
  logic       push_req, pop_req, do_push, do_pop;
  logic       reg_wr, ctrl_wr, thresh_wr, int_en_wr, int_stat_wr, flush;

  assign access   = PSEL & PENABLE;
  assign addr_ok  = (PADDR[30:0] <= 31'h1C);
  assign data_sel = access & addr_ok & PADDR[31];
  assign reg_sel  = access & addr_ok & ~PADDR[31];
  assign reg_idx  = PADDR[4:2];

  assign push_req = data_sel & PWRITE;
  assign pop_req  = data_sel & ~PWRITE;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;

  assign reg_wr      = reg_sel & PWRITE;
  assign ctrl_wr     = reg_wr & (reg_idx == 3'd0);
  assign thresh_wr   = reg_wr & (reg_idx == 3'd2);
  assign int_en_wr   = reg_wr & (reg_idx == 3'd3);
  assign int_stat_wr = reg_wr & (reg_idx == 3'd4);
  assign flush       = ctrl_wr & PSTRB[1] & PWDATA[8];

  // Effective depth = min(8 << depth_sel, MAX_DEPTH); 8 << 15 fits in 20 bits.
  logic [19:0]   depth_raw;
  logic [CW-1:0] depth;
  assign depth_raw = 20'd8 << depth_sel_q;
  assign depth     = (depth_raw >= 20'(MAX_DEPTH)) ? CW'(MAX_DEPTH) : depth_raw[CW-1:0];

  // Flags from registered count
  logic [15:0] count16;
  assign count16      = 16'(count_q);
  assign empty        = (count_q == '0);
  assign full         = (count_q == depth);
  assign almost_full  = (count16 >= af_thresh_q);
  assign almost_empty = (count16 <= ae_thresh_q);

  assign PREADY = 1'b1;
  assign irq    = |(int_stat_q & int_en_q);

  logic [AW-1:0] w_ptr_inc, r_ptr_inc;
  assign w_ptr_inc = ({1'b0, w_ptr_q} == depth - CW'(1)) ? '0 : w_ptr_q + AW'(1);
  assign r_ptr_inc = ({1'b0, r_ptr_q} == depth - CW'(1)) ? '0 : r_ptr_q + AW'(1);

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    depth_sel_d = depth_sel_q;
    af_thresh_d = af_thresh_q;
    ae_thresh_d = ae_thresh_q;
    int_en_d    = int_en_q;

    if (do_push) begin
      w_ptr_d = w_ptr_inc;
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      r_ptr_d = r_ptr_inc;
      count_d = count_q - CW'(1);
    end

    // A depth change only happens with an empty (or flushed) FIFO, so the
    // pointers are re-based to 0 to keep them inside the new range.
    if (ctrl_wr && PSTRB[0] && (count_q == '0 || flush)) begin
      depth_sel_d = PWDATA[3:0];
      w_ptr_d     = '0;
      r_ptr_d     = '0;
    end

    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end

    if (thresh_wr) begin
      if (PSTRB[0]) af_thresh_d[7:0]  = PWDATA[7:0];
      if (PSTRB[1]) af_thresh_d[15:8] = PWDATA[15:8];
      if (PSTRB[2]) ae_thresh_d[7:0]  = PWDATA[23:16];
      if (PSTRB[3]) ae_thresh_d[15:8] = PWDATA[31:24];
    end

    if (int_en_wr && PSTRB[0]) int_en_d = PWDATA[3:0];
  end

  // Interrupt status: hardware set takes priority over a W1C in the same cycle.
  logic [3:0] int_set, int_clr;
  always_comb begin
    int_set    = {almost_empty & ~ae_prev_q,
                  almost_full  & ~af_prev_q,
                  pop_req  & empty,
                  push_req & full};
    int_clr    = (int_stat_wr && PSTRB[0]) ? PWDATA[3:0] : '0;
    int_stat_d = (int_stat_q & ~int_clr) | int_set;
    af_prev_d  = almost_full;
    ae_prev_d  = almost_empty;
  end

  // Read data / error response
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        PSLVERR = 1'b1;
      end else if (PADDR[31]) begin
        if (PWRITE) begin
          PSLVERR = full;
        end else if (empty) begin
          PSLVERR = 1'b1;
        end else begin
          PRDATA = 32'(mem[r_ptr_q]);
        end
      end else if (!PWRITE) begin
        case (reg_idx)
          3'd0:    PRDATA = {28'd0, depth_sel_q};
          3'd1:    PRDATA = {count16, 12'd0, almost_full, almost_empty, full, empty};
          3'd2:    PRDATA = {ae_thresh_q, af_thresh_q};
          3'd3:    PRDATA = {28'd0, int_en_q};
          3'd4:    PRDATA = {28'd0, int_stat_q};
          default: PRDATA = '0;
        endcase
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[w_ptr_q] <= PWDATA[WIDTH-1:0];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      depth_sel_q <= '0;
      af_thresh_q <= 16'(AF_RESET);
      ae_thresh_q <= 16'(AE_RESET);
      int_en_q    <= '0;
      int_stat_q  <= '0;
      // Match the flag values seen with count 0 so reset causes no rise.
      af_prev_q   <= (16'(AF_RESET) == 16'd0);
      ae_prev_q   <= 1'b1;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      depth_sel_q <= depth_sel_d;
      af_thresh_q <= af_thresh_d;
      ae_thresh_q <= ae_thresh_d;
      int_en_q    <= int_en_d;
      int_stat_q  <= int_stat_d;
      af_prev_q   <= af_prev_d;
      ae_prev_q   <= ae_prev_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{PPROT, PADDR[1:0]};

endmodule

// File: doc/apb_fifo_ctrl.md
# apb_fifo_ctrl

Parametrised APB-slave synchronous FIFO: a next-generation FIFO peripheral with data width and maximum depth set at elaboration and run-time depth selection. Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors, flush, and a maskable interrupt. Sits on the peripheral APB bus.

## Interface
- WIDTH, 8: data width, 1..32.
- MAX_DEPTH, 256: storage entries, power of 2, 8..4096.
- AF_RESET, 6: almost-full threshold reset value.
- AE_RESET, 2: almost-empty threshold reset value.

- PCLK  in  1  clock; single clock domain.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  32  bit 31 = 1 data port, 0 register space; [4:2] register index.
- PPROT  in  3  ignored.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte strobes (register writes only).
- PREADY  out  1  tied 1, no wait states.
- PRDATA  out  32  read data, zero-extended.
- PSLVERR  out  1  error response.
- full, empty, almost_full, almost_empty  out  1 each  status.
- irq  out  1  level interrupt.

## Operation
- Access phase = PSEL & PENABLE. Address valid iff PADDR[30:0] <= 0x1C. Invalid address: PSLVERR=1, PRDATA=0, no state change.
- Register map (PADDR[31]=0):
  - 0x00 CTRL RW: [3:0] depth_sel, depth = min(8<<depth_sel, MAX_DEPTH); [8] flush, write-1, reads 0. Reset depth_sel=0.
  - 0x04 STATUS RO: [0] empty, [1] full, [2] almost_empty, [3] almost_full, [31:16] count. Writes ignored, no error.
  - 0x08 THRESH RW: [15:0] af_thresh, [31:16] ae_thresh. Reset AF_RESET/AE_RESET.
  - 0x0C INT_EN RW: [3:0] enables matching INT_STAT bits. Reset 0.
  - 0x10 INT_STAT W1C: [0] overflow, [1] underflow, [2] almost_full rise, [3] almost_empty rise. Reset 0.
  - 0x14–0x1C: read 0, writes ignored, PSLVERR=0.
- Register writes honour PSTRB per byte. CTRL depth_sel update accepted only when count==0 or flush=1 in the same write; otherwise depth_sel holds.
- Data write (PADDR[31]=1, PWRITE=1): if !full push PWDATA[WIDTH-1:0] at w_ptr; else drop, set overflow, PSLVERR=1.
- Data read: if !empty PRDATA = mem[r_ptr] zero-extended, pop; else PRDATA=0, set underflow, PSLVERR=1.
- Pointers wrap to 0 after depth-1. Push and pop are mutually exclusive per APB rules; count changes by at most 1 per cycle.
- Flags, from registered count: empty = count==0; full = count==depth; almost_full = count >= af_thresh; almost_empty = count <= ae_thresh.
- INT_STAT[2]/[3] set on 0→1 transition of almost_full/almost_empty against a 1-cycle-delayed copy. Hardware set wins over same-cycle W1C clear.
- irq = |(INT_STAT & INT_EN).
- Flush: w_ptr, r_ptr, count cleared at next edge; memory contents not cleared; INT_STAT unchanged except edge detection.

## Timing
- Reset: pointers, count 0; empty=1, full=0, almost_empty=1 (AE_RESET≥0), almost_full=0, irq=0, INT_STAT=0, edge-detect copies reset to post-reset flag values (no spurious rise).
- PREADY=1 always; every transfer completes in the access phase.
- PRDATA/PSLVERR combinational in the access phase.
- Push/pop/flush/register update visible at the next PCLK edge; flags and STATUS follow in the same cycle as count.
- INT_STAT edge bits set one cycle after the flag rises; irq asserts the same cycle INT_STAT sets.
- Reset assertion mid-transfer aborts it immediately; all state returns to reset values.

## Test plan
- Reset, read STATUS -> 0x0000_0005; full=0, irq=0.
- Default depth 8: push 0x11..0x18 -> full=1, STATUS count=8; 9th push -> PSLVERR=1, INT_STAT[0]=1; pop 8 -> 0x11..0x18 in order, empty=1.
- CTRL=0x3 (depth 64) while empty, push 64 -> full at count 64; write CTRL=0x1 with count!=0 -> depth_sel stays 3.
- THRESH af=4, ae=1, INT_EN=0x4: push 4 -> almost_full=1, INT_STAT[2]=1, irq=1; write INT_STAT=0x4 -> irq=0.
- Pop when empty -> PRDATA=0, PSLVERR=1, INT_STAT[1]=1; PADDR=0x20 write -> PSLVERR=1, no state change.
- Push 5, write CTRL[8]=1 -> count=0, empty=1 next cycle; pointer wrap: depth 8, 20 push/pop pairs -> data order preserved.
